// File: rtl/mem_store_pkg.sv
// Shared types and default widths for the memory store unit.
// The lookup feature is enabled with MEM_STORE_FWD_EN.
package mem_store_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    WR_HIGH,
    WR_LOW
  } state_t;

  // Default-width layout of one buffered store request.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] high;
    logic [DATA_WIDTH-1:0] low;
    logic                  is_double;
  } store_entry_t;

endpackage

// File: rtl/mem_store_unit_fifo.sv
// Synchronous FIFO (store_fifo) that buffers store requests.
// With MEM_STORE_FWD_EN the storage and read pointer are exported for lookups.
module store_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [width-1:0]       push_data,
  output logic [width-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(depth):0] count
`ifdef MEM_STORE_FWD_EN
  ,
  output logic [depth-1:0][width-1:0] slots,
  output logic [$clog2(depth)-1:0]    rd_ptr
`endif
);

  localparam int unsigned ptr_w = $clog2(depth);

`ifndef MEM_STORE_FWD_EN
  logic [depth-1:0][width-1:0] slots;
  logic [ptr_w-1:0]            rd_ptr;
`endif

  logic [ptr_w-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (ptr_w+1)'(depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

  // Pointers are ptr_w bits wide so they wrap modulo depth on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_store_unit.sv
// Buffers store requests and drains them onto a single memory write port.
// MEM_STORE_FWD_EN adds a combinational lookup of not-yet-retired store data.
module mem_store_unit
  import mem_store_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH,
  parameter int unsigned addr_width = ADDR_WIDTH,
  parameter int unsigned fifo_depth = FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [addr_width-1:0]         req_addr,
  input  logic [data_width-1:0]         req_data_high,
  input  logic [data_width-1:0]         req_data_low,
  input  logic                          req_double,
  output logic                          mem_we,
  output logic [addr_width-1:0]         mem_addr,
  output logic [data_width-1:0]         mem_data,
  output logic                          busy,
  output logic [$clog2(fifo_depth):0]   pending
`ifdef MEM_STORE_FWD_EN
  ,
  input  logic [addr_width-1:0]         lookup_addr,
  output logic                          lookup_hit,
  output logic [data_width-1:0]         lookup_data
`endif
);

  typedef struct packed {
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] high;
    logic [data_width-1:0] low;
    logic                  is_double;
  } entry_t;

  localparam int unsigned entry_w = $bits(entry_t);
  localparam int unsigned ptr_w   = $clog2(fifo_depth);

  state_t                state, state_next;
  entry_t                push_entry, head;
  logic                  fifo_full, fifo_empty, pop;
  logic [ptr_w:0]        fifo_count;
  logic [addr_width-1:0] held_addr;
  logic [data_width-1:0] held_low;
  logic                  held_double;

  assign push_entry = '{addr: req_addr, high: req_data_high, low: req_data_low, is_double: req_double};
  assign req_ready  = !fifo_full;
  assign pending    = fifo_count;
  assign busy       = !fifo_empty || (state != IDLE);

`ifdef MEM_STORE_FWD_EN
  logic [fifo_depth-1:0][entry_w-1:0] fifo_slots;
  logic [ptr_w-1:0]                   fifo_rd_ptr;
`endif

  store_fifo #(
    .width (entry_w),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_valid && !fifo_full),
    .pop       (pop),
    .push_data (push_entry),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
`ifdef MEM_STORE_FWD_EN
    ,
    .slots     (fifo_slots),
    .rd_ptr    (fifo_rd_ptr)
`endif
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = WR_HIGH;
        end
      end
      WR_HIGH: begin
        if (held_double)      state_next = WR_LOW;
        else if (!fifo_empty) pop        = 1'b1;
        else                  state_next = IDLE;
      end
      WR_LOW: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = WR_HIGH;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef MEM_STORE_FWD_EN
  logic [data_width-1:0] held_high;
`endif

  // The popped entry is copied into held_* so its FIFO slot frees immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      held_addr   <= '0;
      held_low    <= '0;
      held_double <= 1'b0;
`ifdef MEM_STORE_FWD_EN
      held_high   <= '0;
`endif
    end else begin
      state <= state_next;
      if (pop) begin
        mem_we      <= 1'b1;
        mem_addr    <= head.addr;
        mem_data    <= head.high;
        held_addr   <= head.addr;
        held_low    <= head.low;
        held_double <= head.is_double;
`ifdef MEM_STORE_FWD_EN
        held_high   <= head.high;
`endif
      end else if (state == WR_HIGH && held_double) begin
        mem_we   <= 1'b1;
        mem_addr <= held_addr + 1'b1;
        mem_data <= held_low;
      end else begin
        mem_we <= 1'b0;
      end
    end
  end

`ifdef MEM_STORE_FWD_EN
  entry_t                slot;
  logic [addr_width-1:0] held_next, slot_next;

  assign held_next = held_addr + 1'b1;

  // Scan oldest to youngest so the youngest matching word is the last one assigned.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    slot        = '0;
    slot_next   = '0;
    if (state != IDLE) begin
      if (held_addr == lookup_addr) begin
        lookup_hit  = 1'b1;
        lookup_data = held_high;
      end
      if (held_double && held_next == lookup_addr) begin
        lookup_hit  = 1'b1;
        lookup_data = held_low;
      end
    end
    for (int unsigned i = 0; i < fifo_depth; i++) begin
      slot      = entry_t'(fifo_slots[fifo_rd_ptr + ptr_w'(i)]);
      slot_next = slot.addr + 1'b1;
      if (i < 32'(fifo_count)) begin
        if (slot.addr == lookup_addr) begin
          lookup_hit  = 1'b1;
          lookup_data = slot.high;
        end
        if (slot.is_double && slot_next == lookup_addr) begin
          lookup_hit  = 1'b1;
          lookup_data = slot.low;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_store_unit.sv
// Scoreboard bench for mem_store_unit: stimulus queues expected writes, a monitor checks them.
module tb_mem_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic [15:0] req_data_high = '0;
  logic [15:0] req_data_low = '0;
  logic        req_double = 1'b0;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        busy;
  logic [2:0]  pending;
`ifdef MEM_STORE_FWD_EN
  logic [15:0] lookup_addr = '0;
  logic        lookup_hit;
  logic [15:0] lookup_data;
`endif

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  compared = 0;
  int  mismatched = 0;

  always #5 clk = ~clk;

  mem_store_unit #(
    .data_width (16),
    .addr_width (16),
    .fifo_depth (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data_high (req_data_high),
    .req_data_low  (req_data_low),
    .req_double    (req_double),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .busy          (busy),
    .pending       (pending)
`ifdef MEM_STORE_FWD_EN
    ,
    .lookup_addr   (lookup_addr),
    .lookup_hit    (lookup_hit),
    .lookup_data   (lookup_data)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: every write seen on the memory port must be the next expected one.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        check("write", {mem_addr, mem_data}, {e.addr, e.data});
      end
    end
  end

  task automatic push(input logic [15:0] a, input logic [15:0] hi, input logic [15:0] lo,
                      input logic dbl, input logic [15:0] lo_addr);
    @(negedge clk);
    req_valid     = 1'b1;
    req_addr      = a;
    req_data_high = hi;
    req_data_low  = lo;
    req_double    = dbl;
    check("req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    exp_q.push_back('{a, hi});
    if (dbl) exp_q.push_back('{lo_addr, lo});
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) return;
    end
    fail_now(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_we",   {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_data", {16'd0, mem_data}, 32'd0);
    check("rst_pending",  {29'd0, pending}, 32'd0);
    check("rst_busy",     {31'd0, busy}, 32'd0);
    check("rst_ready",    {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write, with first-cycle latency checks
    push(16'h0010, 16'hAAAA, 16'h0000, 1'b0, 16'h0000);
    idle();
    #1;
    check("single_pending", {29'd0, pending}, 32'd1);
    check("single_busy",    {31'd0, busy}, 32'd1);
    check("single_latency", {31'd0, mem_we}, 32'd0);
    wait_drain("single_drain");
    @(negedge clk);
    #1;
    check("single_idle_we",   {31'd0, mem_we}, 32'd0);
    check("single_idle_busy", {31'd0, busy}, 32'd0);

    // Double write
    push(16'h0020, 16'h1111, 16'h2222, 1'b1, 16'h0021);
    idle();
    wait_drain("double_drain");
    @(negedge clk);
    #1;
    check("double_idle_busy", {31'd0, busy}, 32'd0);

    // Address wrap on the low word
    push(16'hFFFF, 16'h3333, 16'h5555, 1'b1, 16'h0000);
    idle();
    wait_drain("wrap_drain");
    repeat (2) @(negedge clk);

    // Fill the FIFO behind double stores, then try one refused push
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!req_ready) break;
      req_valid     = 1'b1;
      req_addr      = 16'h0100 + 16'(2 * k);
      req_data_high = 16'h1000 + 16'(k);
      req_data_low  = 16'h2000 + 16'(k);
      req_double    = 1'b1;
      @(posedge clk);
      exp_q.push_back('{16'h0100 + 16'(2 * k), 16'h1000 + 16'(k)});
      exp_q.push_back('{16'h0101 + 16'(2 * k), 16'h2000 + 16'(k)});
    end
    req_addr      = 16'hDEAD;
    req_data_high = 16'hBEEF;
    req_data_low  = 16'hCAFE;
    #1;
    check("full_pending", {29'd0, pending}, 32'd4);
    check("full_ready",   {31'd0, req_ready}, 32'd0);
    idle();
    #1;
    check("full_drop_pending", {29'd0, pending}, 32'd3);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
      check("drain_no_gap", {31'd0, mem_we}, 32'd1);
    end
    wait_drain("full_drain");
    repeat (2) @(negedge clk);

`ifdef MEM_STORE_FWD_EN
    // Forwarding: youngest match wins
    push(16'h0030, 16'h0A0A, 16'h0B0B, 1'b1, 16'h0031);
    push(16'h0031, 16'h0C0C, 16'h0000, 1'b0, 16'h0000);
    idle();
    lookup_addr = 16'h0031;
    #1;
    check("fwd_young", {15'd0, lookup_hit, lookup_data}, {15'd0, 1'b1, 16'h0C0C});
    lookup_addr = 16'h0030;
    #1;
    check("fwd_high", {15'd0, lookup_hit, lookup_data}, {15'd0, 1'b1, 16'h0A0A});
    lookup_addr = 16'h0040;
    #1;
    check("fwd_miss", {15'd0, lookup_hit, lookup_data}, 32'd0);
    wait_drain("fwd_drain");
    repeat (2) @(negedge clk);
`endif

    // Asynchronous reset while the third double store is in WR_HIGH
    for (int k = 0; k < 6; k++)
      push(16'h0300 + 16'(2 * k), 16'h3000 + 16'(k), 16'h4000 + 16'(k), 1'b1, 16'h0301 + 16'(2 * k));
    idle();
    #1;
    check("rstmid_pending",  {29'd0, pending}, 32'd3);
    check("rstmid_we",       {31'd0, mem_we}, 32'd1);
    check("rstmid_addr",     {16'd0, mem_addr}, 32'h0000_0304);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_async_we",  {31'd0, mem_we}, 32'd0);
    check("rstmid_async_pnd", {29'd0, pending}, 32'd0);
    check("rstmid_async_bsy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("post_rst_pending", {29'd0, pending}, 32'd0);
    check("post_rst_busy",    {31'd0, busy}, 32'd0);
    check("post_rst_we",      {31'd0, mem_we}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_store_unit.md
Name: mem_store_unit

Overview:
- Write-side companion to the word-addressed memory, which has a combinational read port and one write port.
- Accepts store requests through a valid/ready handshake and buffers them in a small FIFO.
- Drains each request onto the memory write port as a high word at `addr`, plus an optional low word at `addr+1`.
- Sits between the pipeline store stage and the memory; decouples store issue from memory write timing.

Parameters:
- `data_width`, 16, width of one memory word.
- `addr_width`, 16, memory word-address width.
- `fifo_depth`, 4, number of buffered store requests; must be a power of 2 and ≥ 2.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  a store request is presented.
- `req_ready`  out  1  the FIFO can accept a request; equals `!full`.
- `req_addr`  in  `addr_width`  word address of the high word.
- `req_data_high`  in  `data_width`  word written at `req_addr`.
- `req_data_low`  in  `data_width`  word written at `req_addr+1`.
- `req_double`  in  1  1 = write both words; 0 = write the high word only.
- `mem_we`  out  1  memory write enable, registered.
- `mem_addr`  out  `addr_width`  memory address, registered.
- `mem_data`  out  `data_width`  memory write data, registered.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.
- `pending`  out  `clog2(fifo_depth)+1`  number of entries in the FIFO.

Behaviour:
- **Reset (`rst_n` = 0, asynchronous):** `mem_we`=0, `mem_addr`=0, `mem_data`=0, FIFO emptied, `pending`=0, FSM=IDLE, `busy`=0. Reset mid-operation discards all buffered and in-flight stores; a half-written double store is not completed.
- **Accept:** a request is taken on an edge where `req_valid` && `req_ready`. `req_ready` does not depend on a same-cycle pop, so a full FIFO refuses a push even while popping.
- **FIFO order:** strict first-in first-out. Pointers wrap modulo `fifo_depth`.
- **FSM states:** IDLE, WR_HIGH, WR_LOW.
- **IDLE:**
  - FIFO non-empty → pop the head. Next edge: `mem_we`=1, `mem_addr`=head.addr, `mem_data`=head.high; go to WR_HIGH.
  - FIFO empty → `mem_we`=0; stay in IDLE.
- **WR_HIGH:**
  - Current entry double → next edge: `mem_addr`=addr+1, `mem_data`=low, `mem_we`=1; go to WR_LOW.
  - Otherwise, FIFO non-empty → pop and load the next high word; stay in WR_HIGH.
  - Otherwise, FIFO empty → `mem_we`=0; go to IDLE.
- **WR_LOW:**
  - FIFO non-empty → pop and load the next high word; go to WR_HIGH.
  - FIFO empty → `mem_we`=0; go to IDLE.
- **Latency:** a request accepted at edge N into an empty, idle unit drives `mem_we` from edge N+1. An accept and a pop in the same cycle do not forward; the entry must be resident first, so IDLE sees it on the following cycle.
- **Throughput:** one word per cycle with no bubble between back-to-back entries.
- **Address arithmetic:** `addr+1` is computed modulo `2**addr_width`, so 0xFFFF wraps to 0x0000.
- **Counter:** `pending` increments on push, decrements on pop, and is unchanged on a simultaneous push and pop.
- **Held state:** the current entry (addr, low, double) is held in registers after the pop, so the FIFO slot is freed immediately.

Optional Feature:
- Macro: `MEM_STORE_FWD_EN`.
- **Defined:**
  - Adds inputs `lookup_addr[addr_width]` and outputs `lookup_hit[1]`, `lookup_data[data_width]`, all combinational.
  - Compares `lookup_addr` against every valid FIFO entry and the in-flight held entry: addr matches the high word; addr+1 matches the low word, double entries only.
  - The youngest match wins. Hit → `lookup_data` = the matching word; no hit → `lookup_hit`=0, `lookup_data`=0.
- **Undefined:** the ports do not exist and no comparator logic is generated.

Decomposition:
- **Package `mem_store_pkg`:**
  - FSM state enum `{IDLE, WR_HIGH, WR_LOW}`.
  - Entry struct `{addr, high, low, double}`.
  - Default width constants.
- **Sub-module `store_fifo`:** a synchronous FIFO with push/pop, full/empty and count. The FSM, held-entry registers and forwarding logic stay in the top module.

Test Plan:
- **Single write:** push addr=0x0010, high=0xAAAA, double=0 → exactly one cycle with `mem_we`=1, addr=0x0010, data=0xAAAA; then IDLE and `busy`=0.
- **Double write:** push addr=0x0020, high=0x1111, low=0x2222, double=1 → two consecutive writes: 0x0020←0x1111, then 0x0021←0x2222.
- **Wrap-around:** push addr=0xFFFF, double=1, low=0x5555 → second write lands at 0x0000.
- **Full FIFO:**
  - Hold the FSM busy with double stores and push until `req_ready`=0; `pending`=4.
  - An extra push with `req_valid`=1 is dropped.
  - All accepted stores drain in order with no idle cycles.
- **Reset mid-operation:** assert `rst_n`=0 during WR_HIGH of a double store with 3 pending → `mem_we`=0 immediately (asynchronous); the WR_LOW write never appears; after release `pending`=0.
- **Forwarding (`MEM_STORE_FWD_EN`):** queue 0x0030←{0x0A0A, 0x0B0B} double, then 0x0031←0x0C0C → lookup 0x0031 gives hit=1, data=0x0C0C (youngest); lookup 0x0040 gives hit=0.
